// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_pkg;

  localparam int SAR_W = 8;

  // Comparator flag encodings, ordered {albi, aebi, agbi}.
  localparam logic [2:0] FLAG_LT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_GT = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_DRIVE         = 3'd1,
    ST_SAMPLE        = 3'd2,
    ST_VERIFY_DRIVE  = 3'd3,
    ST_VERIFY_SAMPLE = 3'd4,
    ST_DONE          = 3'd5
  } sar_state_e;

  function automatic logic flags_onehot(input logic [2:0] flags);
    return (flags == FLAG_LT) || (flags == FLAG_EQ) || (flags == FLAG_GT);
  endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Settle countdown: load arms SETTLE_CYC cycles, expire pulses in the last one.
module sar_settle_timer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYC);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: reload, count down to zero, or rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 4'd1);

endmodule

// File: rtl/sar_search.sv
// 8-bit successive-approximation search against an external comparator.
// Optional macro SAR_EARLY_EXIT_EN: stop as soon as a sample reports equality.
module sar_search
  import sar_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [SAR_W-1:0] trial,
  input  logic             albi,
  input  logic             aebi,
  input  logic             agbi,
  output logic             busy,
  output logic             done,
  output logic [SAR_W-1:0] result,
  output logic             found,
  output logic             err
);

  sar_state_e       state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [SAR_W-1:0] result_q, result_d;
  logic [SAR_W-1:0] trial_q, trial_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_s;
  logic             expire_s;
  logic [2:0]       flags_s;

  assign flags_s = {albi, aebi, agbi};

  sar_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .expire_o (expire_s)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    load_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          k_d      = 3'd7;
          load_s   = 1'b1;
          state_d  = ST_DRIVE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (expire_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_SAMPLE: begin
        if (!flags_onehot(flags_s)) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = ST_DONE;
`ifdef SAR_EARLY_EXIT_EN
        end else if (flags_s == FLAG_EQ) begin
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = ST_DONE;
`endif
        end else begin
          if (flags_s != FLAG_GT) begin
            result_d[k_q] = 1'b1;
          end else begin
            result_d[k_q] = 1'b0;
          end
          load_s = 1'b1;
          // k stops at 0; the verify pass follows instead of a wrap.
          if (k_q == 3'd0) begin
            state_d = ST_VERIFY_DRIVE;
          end else begin
            k_d     = k_q - 3'd1;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_VERIFY_DRIVE: begin
        if (expire_s) begin
          state_d = ST_VERIFY_SAMPLE;
        end else begin
          state_d = ST_VERIFY_DRIVE;
        end
      end
      ST_VERIFY_SAMPLE: begin
        if (!flags_onehot(flags_s)) begin
          err_d   = 1'b1;
          found_d = 1'b0;
        end else begin
          found_d = aebi;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    case (state_d)
      ST_DRIVE, ST_SAMPLE:               trial_d = result_d | (8'd1 << k_d);
      ST_VERIFY_DRIVE, ST_VERIFY_SAMPLE: trial_d = result_d;
      default:                           trial_d = 8'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd7;
      result_q <= 8'd0;
      trial_q  <= 8'd0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      result_q <= result_d;
      trial_q  <= trial_d;
      found_q  <= found_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: SETTLE_CYC=1 and SETTLE_CYC=3 instances against
// a behavioural comparator with optional flag override.
module tb_sar_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start0, albi0, aebi0, agbi0, busy0, done0, found0, err0;
  logic [7:0] trial0, result0, tgt0;
  logic       ovr_en0;
  logic [2:0] ovr0;

  logic       start1, albi1, aebi1, agbi1, busy1, done1, found1, err1;
  logic [7:0] trial1, result1, tgt1;
  logic       ovr_en1;
  logic [2:0] ovr1;

  assign {albi0, aebi0, agbi0} = ovr_en0 ? ovr0 : {trial0 < tgt0, trial0 == tgt0, trial0 > tgt0};
  assign {albi1, aebi1, agbi1} = ovr_en1 ? ovr1 : {trial1 < tgt1, trial1 == tgt1, trial1 > tgt1};

  sar_search #(.SETTLE_CYC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .trial(trial0),
    .albi(albi0), .aebi(aebi0), .agbi(agbi0), .busy(busy0), .done(done0),
    .result(result0), .found(found0), .err(err0)
  );

  sar_search #(.SETTLE_CYC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .trial(trial1),
    .albi(albi1), .aebi(aebi1), .agbi(agbi1), .busy(busy1), .done(done1),
    .result(result1), .found(found1), .err(err1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] trq[$];

  task automatic run0(input logic [7:0] t, input logic oe, input logic [2:0] ov, output int cyc);
    tgt0 = t; ovr_en0 = oe; ovr0 = ov;
    trq.delete();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 200) begin
      if (trial0 != 8'd0 && (trq.size() == 0 || trq[$] != trial0)) trq.push_back(trial0);
      @(negedge clk); cyc++;
    end
    if (cyc >= 200) check("u0_timeout", 32'd1, 32'd0);
  endtask

  task automatic run1(input logic [7:0] t, input logic oe, input logic [2:0] ov, output int cyc);
    tgt1 = t; ovr_en1 = oe; ovr1 = ov;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    if (cyc >= 300) check("u1_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] target;
    logic       oe;
    logic [2:0] ov;
    logic [7:0] exp_res;
    logic       exp_found;
    logic       exp_err;
    int         exp_cyc;
  } vec_t;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  vec_t v0[9];
  vec_t v1[3];
  logic [7:0] exp_tr[$];

  initial begin
    int cyc;
    int hold_done;

    v0[0] = '{"t5A",   8'h5A, 1'b0, 3'b000, 8'h5A, 1'b1, 1'b0, EE ? 15 : 19};
    v0[1] = '{"t00",   8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 19};
    v0[2] = '{"tFF",   8'hFF, 1'b0, 3'b000, 8'hFF, 1'b1, 1'b0, EE ? 17 : 19};
    v0[3] = '{"f000",  8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 3};
    v0[4] = '{"f111",  8'h00, 1'b1, 3'b111, 8'h00, 1'b0, 1'b1, 3};
    v0[5] = '{"allLT", 8'h00, 1'b1, 3'b100, 8'hFF, 1'b0, 1'b0, 19};
    v0[6] = '{"allGT", 8'h00, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 19};
    v0[7] = '{"allEQ", 8'h00, 1'b1, 3'b010, EE ? 8'h80 : 8'hFF, 1'b1, 1'b0, EE ? 3 : 19};
    v0[8] = '{"t80",   8'h80, 1'b0, 3'b000, 8'h80, 1'b1, 1'b0, EE ? 3 : 19};

    v1[0] = '{"s3_00", 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 37};
    v1[1] = '{"s3_FF", 8'hFF, 1'b0, 3'b000, 8'hFF, 1'b1, 1'b0, EE ? 33 : 37};
    v1[2] = '{"s3_f0", 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 5};

    // Reset with random inputs: everything must stay at zero.
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    tgt0 = 8'h3C; tgt1 = 8'h00; ovr_en0 = 1'b0; ovr_en1 = 1'b0; ovr0 = 3'b000; ovr1 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start0 = 1'($urandom); start1 = 1'($urandom);
      ovr_en0 = 1'b1; ovr0 = 3'($urandom); ovr_en1 = 1'b1; ovr1 = 3'($urandom);
      #1;
      check("reset_u0", {trial0, result0, busy0, done0, found0, err0}, 32'd0);
      check("reset_u1", {trial1, result1, busy1, done1, found1, err1}, 32'd0);
    end
    @(negedge clk);
    ovr_en0 = 1'b0; ovr_en1 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("first_start_busy", busy0, 1'b1);
    cyc = 1;
    while (!done0 && cyc < 200) begin @(negedge clk); cyc++; end
    check("first_result", result0, 8'h3C);

    // Main vector table on the SETTLE_CYC=1 instance.
    foreach (v0[i]) begin
      run0(v0[i].target, v0[i].oe, v0[i].ov, cyc);
      check({v0[i].name, "_cyc"}, cyc, v0[i].exp_cyc);
      check({v0[i].name, "_res"}, result0, v0[i].exp_res);
      check({v0[i].name, "_found"}, found0, v0[i].exp_found);
      check({v0[i].name, "_err"}, err0, v0[i].exp_err);
      if (i == 0) begin
        exp_tr = EE ? '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A}
                    : '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B, 8'h5A};
        check("t5A_ntrials", trq.size(), exp_tr.size());
        for (int j = 0; j < exp_tr.size() && j < trq.size(); j++)
          check($sformatf("t5A_trial%0d", j), trq[j], exp_tr[j]);
      end
      @(negedge clk);
      check({v0[i].name, "_pulse"}, {done0, busy0, trial0}, 32'd0);
      check({v0[i].name, "_hold"}, {result0, found0, err0},
            {v0[i].exp_res, v0[i].exp_found, v0[i].exp_err});
    end

    // Longer settle time.
    foreach (v1[i]) begin
      run1(v1[i].target, v1[i].oe, v1[i].ov, cyc);
      check({v1[i].name, "_cyc"}, cyc, v1[i].exp_cyc);
      check({v1[i].name, "_res"}, result1, v1[i].exp_res);
      check({v1[i].name, "_found"}, found1, v1[i].exp_found);
      check({v1[i].name, "_err"}, err1, v1[i].exp_err);
    end

    // Start held high: ignored while busy and in DONE, accepted in the following IDLE.
    hold_done = EE ? 17 : 19;
    tgt0 = 8'hA5; ovr_en0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    cyc = 0;
    while (cyc < hold_done + 2) begin
      @(negedge clk); cyc++;
      if (cyc == hold_done) check("hold_done", done0, 1'b1);
      if (cyc == hold_done) check("hold_res", result0, 8'hA5);
      if (cyc == hold_done + 1) check("hold_idle_busy", busy0, 1'b0);
      if (cyc == hold_done + 2) check("hold_restart_busy", busy0, 1'b1);
    end
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 200) begin @(negedge clk); cyc++; end
    check("hold_res2", result0, 8'hA5);

    // Mid-search reset with a stray start while busy.
    tgt0 = 8'h33;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(negedge clk); cyc++;
      if (cyc == 3) start0 = 1'b1;
      if (cyc == 4) start0 = 1'b0;
    end
    check("mid_trial_c5", trial0, 8'h20);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out", {trial0, result0, busy0, done0, found0, err0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run0(8'hC7, 1'b0, 3'b000, cyc);
    check("post_reset_res", result0, 8'hC7);
    check("post_reset_found", found0, 1'b1);
    check("post_reset_cyc", cyc, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter SETTLE_CYC, default 1, number of cycles the trial word is held before the comparator flags are sampled; legal range 1..15.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  search request, sampled only in IDLE.
REQ-005 trial  output  8  trial word driven onto the comparator A bus (bit 7 = A7).
REQ-006 albi  input  1  comparator result, trial < target.
REQ-007 aebi  input  1  comparator result, trial == target.
REQ-008 agbi  input  1  comparator result, trial > target.
REQ-009 busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  8  recovered target value, held from DONE until the next accepted start.
REQ-012 found  output  1  final check reported equality; valid with done, held like result.
REQ-013 err  output  1  comparator flags were not one-hot during a sample; held like result.

Function
REQ-014 States SHALL be IDLE, DRIVE, SAMPLE, VERIFY_DRIVE, VERIFY_SAMPLE, DONE.
REQ-015 IDLE: start=1 at an edge SHALL clear result/found/err, set bit index k=7, and move to DRIVE.
REQ-016 DRIVE SHALL drive trial = result | (1<<k) for exactly SETTLE_CYC cycles, then move to SAMPLE.
REQ-017 SAMPLE, trial still driven: agbi=1 SHALL leave bit k clear; albi=1 or aebi=1 SHALL set bit k in result; then k=0 -> VERIFY_DRIVE, else k-1 -> DRIVE.
REQ-018 VERIFY_DRIVE SHALL drive trial = result for SETTLE_CYC cycles; VERIFY_SAMPLE SHALL set found = aebi, then move to DONE.
REQ-019 Any sample whose {albi,aebi,agbi} is not exactly one-hot SHALL set err=1 and found=0 and go directly to DONE; result holds bits resolved so far.
REQ-020 DONE SHALL assert done for one cycle and return to IDLE; trial SHALL be 0 in IDLE and DONE.
REQ-021 Latency without early exit: done high in cycle 9*(SETTLE_CYC+1)+1 after the accepting edge (19 at default).
REQ-022 start during busy SHALL be ignored; start high in the DONE cycle SHALL be ignored; start in IDLE directly after DONE SHALL be accepted.
REQ-023 Target 0x00 and 0xFF SHALL resolve correctly; no arithmetic wrap of k below 0.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, trial=0, result=0, busy=0, done=0, found=0, err=0, k=7, settle counter 0, including mid-search.
REQ-025 First start SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro SAR_EARLY_EXIT_EN defined: aebi=1 in SAMPLE SHALL set result = trial, found=1, and go directly to DONE, skipping the remaining bits and verify phase.
REQ-027 SAR_EARLY_EXIT_EN undefined: aebi in SAMPLE SHALL be treated like albi per REQ-017; all 8 bits plus verify always run.

Structure
REQ-028 Package sar_pkg SHALL hold the state enum, width constant SAR_W=8, and the flag encoding constants.
REQ-029 Settle countdown SHALL be a sub-module sar_settle_timer (load SETTLE_CYC, expire pulse); all else in sar_search.

Verification
REQ-030 Reset with random start/flags -> all outputs 0; release, start -> busy next cycle.
REQ-031 Target 0x5A, SETTLE_CYC=1, no early exit -> trial 80,40,60,50,58,5C,5A,5B then 5A; done in cycle 19; result=0x5A, found=1, err=0.
REQ-032 Same with SAR_EARLY_EXIT_EN -> exit at trial 0x5A; done in cycle 15; result=0x5A, found=1.
REQ-033 Targets 0x00 and 0xFF, SETTLE_CYC=3 -> result 0x00/0xFF, found=1, done in cycle 37.
REQ-034 Flags forced 000 at first sample -> err=1, found=0, result=0x00, done pulse in cycle 3.
REQ-035 rst_n low in cycle 5 of a search, start pulsed while busy -> outputs 0 at once; extra start ignored; next search yields correct result.
